alu_seq_unit: RTL and testbench

- Parametrised successor to the single-cycle ALU-control decoder.
- Combines aluop/funct decode with a registered ALU datapath of WIDTH bits.
- Variable shifts (sllv, srlv) execute iteratively, one bit per cycle.
- Single start/done handshake; sits between the multicycle control FSM and the register-file write-back path.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq_decode.sv | 40 ++++
 rtl/alu_seq_unit.sv | 146 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: aluop, funct, ALU ctl codes, FSM states.
// Pure declarations; no logic, no latency, no backpressure.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_AND   = 2'b11
    } aluop_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;

    typedef enum logic [2:0] {
        CTL_AND  = 3'b000,
        CTL_OR   = 3'b001,
        CTL_ADD  = 3'b010,
        CTL_SLLV = 3'b100,
        CTL_SRLV = 3'b101,
        CTL_SUB  = 3'b110,
        CTL_SLT  = 3'b111
    } ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
// Wires only; start is honoured by the slave only while ready is high.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output start, aluop, funct, a, b,
        input  ready, done, result, zero, illegal
    );

    modport slave (
        input  start, aluop, funct, a, b,
        output ready, done, result, zero, illegal
    );
endinterface

// File: rtl/alu_seq_decode.sv
// ALU-control decode: (aluop, funct) -> ctl code, illegal flag, shift flag.
// Purely combinational, zero latency, no backpressure.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output ctl_e       ctl_o,
    output logic       illegal_o,
    output logic       is_shift_o
);
    always_comb begin
        ctl_o      = CTL_ADD;
        illegal_o  = 1'b0;
        is_shift_o = 1'b0;
        unique case (aluop_i)
            ALUOP_ADD: ctl_o = CTL_ADD;
            ALUOP_SUB: ctl_o = CTL_SUB;
            ALUOP_AND: ctl_o = CTL_AND;
            default: begin
                case (funct_i)
                    FN_ADD:  ctl_o = CTL_ADD;
                    FN_SUB:  ctl_o = CTL_SUB;
                    FN_SLT:  ctl_o = CTL_SLT;
                    FN_OR:   ctl_o = CTL_OR;
                    FN_AND:  ctl_o = CTL_AND;
                    FN_SLLV: begin
                        ctl_o      = CTL_SLLV;
                        is_shift_o = 1'b1;
                    end
                    FN_SRLV: begin
                        ctl_o      = CTL_SRLV;
                        is_shift_o = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with start/done handshake; sllv/srlv iterate one bit per cycle
// unless ALU_SEQ_BARREL_EN is defined (barrel shifter, every op latency 1).
// Latency 1 (shift by n: n+1); ready low while busy, start ignored then.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus
);
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 illegal_q, illegal_d;

    ctl_e                 dec_ctl;
    logic                 dec_illegal;
    logic                 dec_is_shift;
    logic [SHAMT_W-1:0]   shamt;

    alu_seq_decode u_decode (
        .aluop_i    (bus.aluop),
        .funct_i    (bus.funct),
        .ctl_o      (dec_ctl),
        .illegal_o  (dec_illegal),
        .is_shift_o (dec_is_shift)
    );

    assign shamt = bus.a[SHAMT_W-1:0];

    // Shift ctl codes fall through to b, which is the zero-amount shift result.
    function automatic logic [WIDTH-1:0] alu_eval(ctl_e ctl, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
        case (ctl)
            CTL_ADD: alu_eval = x + y;
            CTL_SUB: alu_eval = x - y;
            CTL_AND: alu_eval = x & y;
            CTL_OR:  alu_eval = x | y;
            CTL_SLT: alu_eval = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            default: alu_eval = y;
        endcase
    endfunction

`ifdef ALU_SEQ_BARREL_EN
    logic [WIDTH-1:0] shift_res;
    assign shift_res = (dec_ctl == CTL_SLLV) ? (bus.b << shamt) : (bus.b >> shamt);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    result_d  = dec_illegal  ? '0 :
                                dec_is_shift ? shift_res : alu_eval(dec_ctl, bus.a, bus.b);
                    zero_d    = (result_d == '0);
                    illegal_d = dec_illegal;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    ctl_e               ctl_q, ctl_d;
    logic [WIDTH-1:0]   sreg_step;

    assign sreg_step = (ctl_q == CTL_SLLV) ? (sreg_q << 1) : (sreg_q >> 1);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        ctl_d     = ctl_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ctl_d = dec_ctl;
                    if (!dec_illegal && dec_is_shift && (shamt != '0)) begin
                        sreg_d  = bus.b;
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d  = dec_illegal ? '0 : alu_eval(dec_ctl, bus.a, bus.b);
                        zero_d    = (result_d == '0);
                        illegal_d = dec_illegal;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                sreg_d = sreg_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    result_d  = sreg_step;
                    zero_d    = (sreg_step == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            ctl_q  <= CTL_ADD;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            ctl_q  <= ctl_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: driver pushes model predictions, monitor checks on done.
module tb_alu_seq_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        bit           zero;
        bit           ill;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   ready_seen = 0;

`ifdef ALU_SEQ_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model: direct arithmetic on the instruction semantics.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   n;
        bit   shift;
        e.ill = 0;
        e.res = '0;
        shift = 0;
        n     = int'(x % 32);
        case (op)
            2'b00: e.res = x + y;
            2'b01: e.res = x - y;
            2'b11: e.res = x & y;
            default: begin
                case (fn)
                    6'd32: e.res = x + y;
                    6'd34: e.res = x - y;
                    6'd42: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
                    6'd37: e.res = x | y;
                    6'd36: e.res = x & y;
                    6'd4:  begin e.res = y * (64'd1 << n); shift = 1; end
                    6'd6:  begin e.res = y / (64'd1 << n); shift = 1; end
                    default: e.ill = 1;
                endcase
            end
        endcase
        e.zero = (e.res == 0);
        e.lat  = (shift && !BARREL && n > 0) ? n + 1 : 1;
        return e;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (bus.ready !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                chk("ready_timeout", {31'b0, bus.ready}, 1);
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        exp_t e;
        int   t;
        wait_ready();
        bus.aluop = op; bus.funct = fn; bus.a = x; bus.b = y; bus.start = 1'b1;
        e      = model(op, fn, x, y);
        e.acc  = cyc;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.a = $urandom; bus.b = $urandom;
        bus.aluop = 2'($urandom); bus.funct = 6'($urandom);
        if (hold) begin
            t = 0;
            while (bus.ready !== 1'b1 && t < 200) begin
                @(posedge clk); #1;
                bus.a = $urandom; bus.b = $urandom;
                t++;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: every done pops one prediction and checks data, flags and latency.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() != 0 && cyc > exp_q[0].acc && bus.ready === 1'b1 && bus.done !== 1'b1)
                ready_seen = 1;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_result"},  bus.result, e.res);
                    chk({e.name, "_zero"},    {31'b0, bus.zero}, {31'b0, e.zero});
                    chk({e.name, "_illegal"}, {31'b0, bus.illegal}, {31'b0, e.ill});
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                    chk({e.name, "_ready_low"}, {31'b0, ready_seen | bus.ready}, 0);
                end
                ready_seen = 0;
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        logic [5:0] fns [8];
        fns = '{6'd32, 6'd34, 6'd42, 6'd37, 6'd36, 6'd4, 6'd6, 6'd63};
        bus.start = 0; bus.aluop = 0; bus.funct = 0; bus.a = 0; bus.b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   {31'b0, bus.ready}, 1);
        chk("rst_done",    {31'b0, bus.done}, 0);
        chk("rst_result",  bus.result, 0);
        chk("rst_zero",    {31'b0, bus.zero}, 0);
        chk("rst_illegal", {31'b0, bus.illegal}, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        run_op("sub_rtype", 2'b10, 6'b100010, 32'd5, 32'd7, 0);
        run_op("slt_neg",   2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0);
        run_op("add_zero",  2'b00, 6'd0, 32'd3, -32'sd3, 0);
        run_op("sllv_4",    2'b10, 6'b000100, 32'd4, 32'h0000000F, 0);
        run_op("srlv_0",    2'b10, 6'b000110, 32'd0, 32'h80000000, 0);
        run_op("srlv_31",   2'b10, 6'b000110, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("hold_sllv", 2'b10, 6'b000100, 32'd9, 32'h00000003, 1);
        run_op("illegal",   2'b10, 6'b111111, 32'd12, 32'd34, 0);
        run_op("and_op",    2'b11, 6'd0, 32'h0000F0F0, 32'h0000FF00, 0);
        run_op("add_pre",   2'b00, 6'd0, 32'd5, 32'd7, 0);
        drain();

        // Reset asserted part-way through a long shift.
        run_op("sllv_20", 2'b10, 6'b000100, 32'd20, 32'h00000001, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        exp_q.delete();
        ready_seen = 0;
        chk("midrst_ready",  {31'b0, bus.ready}, 1);
        chk("midrst_done",   {31'b0, bus.done}, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_zero",   {31'b0, bus.zero}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        repeat (30) @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom);
            fn = fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run_op("rand", op, fn, $urandom, $urandom, bit'($urandom_range(0, 3) == 0));
        end
        drain();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
